// File: rtl/ser_piso_pkg.sv
// ============================================================================
// ser_pkg : shared types and helpers for the ser_piso serialiser
// Revision: 1.0
// ============================================================================
`default_nettype none

package ser_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bounded loop keeps the function elaboration-friendly for synthesis
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ser_piso_if.sv
// ============================================================================
// ser_piso_if : parallel-in and serial-out handshake bundle for ser_piso
// Revision: 1.0
// ============================================================================
`default_nettype none

interface ser_piso_if #(
  parameter int W = 8
);
  logic [W-1:0] i_data;
  logic         i_valid;
  logic         i_ready;
  logic         q;
  logic         q_valid;
  logic         q_last;
  logic         o_ready;

  modport master (
    output i_data, i_valid, o_ready,
    input  i_ready, q, q_valid, q_last
  );

  modport slave (
    input  i_data, i_valid, o_ready,
    output i_ready, q, q_valid, q_last
  );
endinterface

`default_nettype wire

// File: rtl/ser_piso_stage.sv
// ============================================================================
// ser_stage : one shift-register bit, mx2 select feeding an async-clear flop
// Revision: 1.0
// ============================================================================
`default_nettype none

module ser_stage (
  input  wire  ck,
  input  wire  nrst,
  input  wire  en,
  input  wire  cmd,
  input  wire  i0,
  input  wire  i1,
  output logic q
);

  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      q <= 1'b0;
    end else if (en) begin
      q <= cmd ? i1 : i0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ser_piso.sv
// ============================================================================
// ser_piso : valid/ready parallel-in serial-out serialiser, W bits per word
// Revision: 1.0
// ============================================================================
`default_nettype none

module ser_piso
  import ser_pkg::*;
#(
  parameter int W         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input wire       ck,
  input wire       nrst,
  ser_piso_if.slave s
);

  localparam int            CW     = clog2(W);
  localparam logic [CW-1:0] C_LAST = CW'(W - 1);

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic [W-1:0]  r_shreg;
  logic [W-1:0]  w_nbr;
  logic          w_count_zero;
  logic          w_in_ready;
  logic          w_load;
  logic          w_shift;
  logic          w_en;
  logic          w_out_bit;

  assign w_count_zero = (r_count == '0);
  assign w_in_ready   = nrst & ((r_state == IDLE) |
                                ((r_state == SHIFT) & w_count_zero & s.o_ready));
  assign w_load       = w_in_ready & s.i_valid;
  assign w_shift      = (r_state == SHIFT) & s.o_ready & ~w_count_zero;
  assign w_en         = w_load | w_shift;

  // Each bit takes its neighbour one step further from the output end
  generate
    if (MSB_FIRST) begin : g_msb
      assign w_nbr = {r_shreg[W-2:0], 1'b0};
    end else begin : g_lsb
      assign w_nbr = {1'b0, r_shreg[W-1:1]};
    end
  endgenerate

  generate
    for (genvar k = 0; k < W; k++) begin : g_stage
      ser_stage u_stage (
        .ck   (ck),
        .nrst (nrst),
        .en   (w_en),
        .cmd  (w_load),
        .i0   (w_nbr[k]),
        .i1   (s.i_data[k]),
        .q    (r_shreg[k])
      );
    end
  endgenerate

  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_load) begin
            r_state <= SHIFT;
            r_count <= C_LAST;
          end
        end
        SHIFT: begin
          if (s.o_ready) begin
            if (!w_count_zero) begin
              r_count <= r_count - 1'b1;
            end else if (s.i_valid) begin
              r_count <= C_LAST;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_count <= '0;
        end
      endcase
    end
  end

  assign w_out_bit = MSB_FIRST ? r_shreg[W-1] : r_shreg[0];

  // Outputs depend only on flops, never on i_data
  assign s.q       = (r_state == SHIFT) & w_out_bit;
  assign s.q_valid = (r_state == SHIFT);
  assign s.q_last  = (r_state == SHIFT) & w_count_zero;
  assign s.i_ready = w_in_ready;

endmodule

`default_nettype wire

// File: tb/tb_ser_piso.sv
// ============================================================================
// tb_ser_piso : directed self-checking bench for ser_piso (MSB and LSB first)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ser_piso;

  logic ck;
  logic nrst;
  int   errors;
  int   checks;

  ser_piso_if #(.W(8)) bm ();
  ser_piso_if #(.W(8)) bl ();

  ser_piso #(.W(8), .MSB_FIRST(1'b1)) u_dut_m (.ck(ck), .nrst(nrst), .s(bm.slave));
  ser_piso #(.W(8), .MSB_FIRST(1'b0)) u_dut_l (.ck(ck), .nrst(nrst), .s(bl.slave));

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] d;
    int acc;
    int cyc;
    errors = 0;
    checks = 0;
    nrst = 1'b0;
    bm.i_data = '0; bm.i_valid = 1'b0; bm.o_ready = 1'b1;
    bl.i_data = '0; bl.i_valid = 1'b0; bl.o_ready = 1'b1;

    // Reset state
    #1;
    chk("rst_q", bm.q, 0);
    chk("rst_qv", bm.q_valid, 0);
    chk("rst_ql", bm.q_last, 0);
    chk("rst_ir", bm.i_ready, 0);
    chk("rst_ir_l", bl.i_ready, 0);
    tick();
    tick();
    nrst = 1'b1;
    #1;
    chk("idle_ir", bm.i_ready, 1);
    chk("idle_qv", bm.q_valid, 0);

    // MSB first, A5
    d = 8'hA5;
    bm.i_data = d; bm.i_valid = 1'b1;
    tick();
    bm.i_valid = 1'b0;
    for (int b = 0; b < 8; b++) begin
      chk("msb_q", bm.q, d[7-b]);
      chk("msb_qv", bm.q_valid, 1);
      chk("msb_ql", bm.q_last, (b == 7));
      chk("msb_ir", bm.i_ready, (b == 7));
      tick();
    end
    chk("msb_end_qv", bm.q_valid, 0);
    chk("msb_end_ir", bm.i_ready, 1);

    // LSB first, 01
    d = 8'h01;
    bl.i_data = d; bl.i_valid = 1'b1;
    tick();
    bl.i_valid = 1'b0;
    for (int b = 0; b < 8; b++) begin
      chk("lsb_q", bl.q, d[b]);
      chk("lsb_qv", bl.q_valid, 1);
      chk("lsb_ql", bl.q_last, (b == 7));
      tick();
    end
    chk("lsb_end_qv", bl.q_valid, 0);

    // Back-to-back FF then 00, second word taken on the first word's last beat
    bm.i_data = 8'hFF; bm.i_valid = 1'b1;
    tick();
    bm.i_data = 8'h00;
    for (int b = 0; b < 16; b++) begin
      if (b == 8) bm.i_valid = 1'b0;
      #1;
      chk("b2b_q", bm.q, (b < 8));
      chk("b2b_qv", bm.q_valid, 1);
      chk("b2b_ql", bm.q_last, (b == 7 || b == 15));
      chk("b2b_ir", bm.i_ready, (b == 7 || b == 15));
      tick();
    end
    chk("b2b_end_qv", bm.q_valid, 0);

    // Backpressure, C3 with o_ready pattern 1,0,0,1
    d = 8'hC3;
    bm.i_data = d; bm.i_valid = 1'b1;
    tick();
    bm.i_valid = 1'b0;
    acc = 0;
    cyc = 0;
    while (acc < 8 && cyc < 40) begin
      bm.o_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      #1;
      chk("bp_q", bm.q, d[7-acc]);
      chk("bp_qv", bm.q_valid, 1);
      chk("bp_ql", bm.q_last, (acc == 7));
      chk("bp_ir", bm.i_ready, (bm.o_ready && acc == 7));
      if (bm.o_ready) acc++;
      cyc++;
      tick();
    end
    chk("bp_beats", acc, 8);
    chk("bp_end_qv", bm.q_valid, 0);
    bm.o_ready = 1'b1;

    // Async reset mid-word after three accepted beats of A5
    d = 8'hA5;
    bm.i_data = d; bm.i_valid = 1'b1;
    tick();
    bm.i_valid = 1'b0;
    tick(); tick(); tick();
    chk("mid_q", bm.q, d[4]);
    chk("mid_qv", bm.q_valid, 1);
    #2;
    nrst = 1'b0;
    #1;
    chk("arst_q", bm.q, 0);
    chk("arst_qv", bm.q_valid, 0);
    chk("arst_ql", bm.q_last, 0);
    chk("arst_ir", bm.i_ready, 0);
    tick();
    nrst = 1'b1;
    #1;
    chk("rel_ir", bm.i_ready, 1);
    for (int b = 0; b < 10; b++) begin
      chk("rel_qv", bm.q_valid, 0);
      chk("rel_q", bm.q, 0);
      tick();
    end

    // i_data wiggles during SHIFT must not reach q
    d = 8'h96;
    bm.i_data = d; bm.i_valid = 1'b1;
    tick();
    bm.i_valid = 1'b0;
    for (int b = 0; b < 8; b++) begin
      bm.i_data = 8'($urandom);
      #1;
      chk("hold_q", bm.q, d[7-b]);
      chk("hold_ql", bm.q_last, (b == 7));
      tick();
    end
    chk("hold_end_qv", bm.q_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
